// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: chunked PARITY/POPCOUNT reduction and single-cycle rotates,
// with one command in flight and a valid/ready response held until consumed.
module alu_seq_ctrl #(
    parameter int unsigned DATA_WIDTH  = 1024,
    parameter int unsigned CHUNK_WIDTH = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [2:0]                    i_cmd_opcode,
    input  logic [DATA_WIDTH-1:0]         i_cmd_data,
    input  logic [$clog2(DATA_WIDTH)-1:0] i_cmd_shamt,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [2:0]                    o_rsp_opcode,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_busy
);

    localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned SW     = $clog2(DATA_WIDTH);
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [2:0] OpParity = 3'd0;
    localparam logic [2:0] OpRotr   = 3'd2;
    localparam logic [2:0] OpRotl   = 3'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [SW-1:0]           r_shamt;
    logic [IW-1:0]           r_idx;
    logic [SW:0]             r_acc;
    logic [2:0]              r_rsp_op;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_err;

    logic                    w_accept;
    logic                    w_is_rot;
    logic                    w_last;
    logic [CHUNK_WIDTH-1:0]  w_chunk;
    logic [SW:0]             w_acc_nxt;
    logic [SW:0]             w_inv;
    logic [DATA_WIDTH-1:0]   w_rotr;
    logic [DATA_WIDTH-1:0]   w_rotl;

    function automatic logic [SW:0] f_popcnt(input logic [CHUNK_WIDTH-1:0] v);
        logic [SW:0] c;
        c = '0;
        for (int i = 0; i < int'(CHUNK_WIDTH); i++) begin
            c = c + {{SW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_accept = i_cmd_valid && (r_state == StIdle);
    assign w_is_rot = (r_op == OpRotr) || (r_op == OpRotl);
    assign w_last   = (r_idx == IW'(NCHUNK - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            StIdle: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                // Illegal opcodes (bit 2 set) skip RUN and answer immediately.
                if (i_cmd_valid) begin
                    w_state_nxt = i_cmd_opcode[2] ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_is_rot || w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_chunk = '0;
        for (int k = 0; k < int'(NCHUNK); k++) begin
            if (r_idx == IW'(k)) begin
                w_chunk = r_data[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    always_comb begin
        if (r_op == OpParity) begin
            w_acc_nxt = {{SW{1'b0}}, r_acc[0] ^ (^w_chunk)};
        end else begin
            w_acc_nxt = r_acc + f_popcnt(w_chunk);
        end
    end

    // A shift by the full width yields zero, so shamt 0 leaves the operand intact.
    assign w_inv  = (SW+1)'(DATA_WIDTH) - {1'b0, r_shamt};
    assign w_rotr = (r_data >> r_shamt) | (r_data << w_inv);
    assign w_rotl = (r_data << r_shamt) | (r_data >> w_inv);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op       <= '0;
            r_data     <= '0;
            r_shamt    <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_rsp_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_op     <= i_cmd_opcode;
            r_data   <= i_cmd_data;
            r_shamt  <= i_cmd_shamt;
            r_idx    <= '0;
            r_acc    <= '0;
            r_rsp_op <= i_cmd_opcode;
            r_rsp_err <= i_cmd_opcode[2];
            if (i_cmd_opcode[2]) begin
                r_rsp_data <= '0;
            end
        end else if (r_state == StRun) begin
            if (w_is_rot) begin
                r_rsp_data <= (r_op == OpRotl) ? w_rotl : w_rotr;
            end else begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    r_rsp_data <= DATA_WIDTH'(w_acc_nxt);
                end
            end
        end
    end

    assign o_rsp_opcode = r_rsp_op;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_alu_seq_ctrl;

    localparam int unsigned DW  = 1024;
    localparam int unsigned CW  = 64;
    localparam int unsigned NCH = DW / CW;
    localparam int unsigned SW  = $clog2(DW);

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_shamt;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_opcode;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    alu_seq_ctrl #(
        .DATA_WIDTH  (DW),
        .CHUNK_WIDTH (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_opcode (cmd_opcode),
        .i_cmd_data   (cmd_data),
        .i_cmd_shamt  (cmd_shamt),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_opcode (rsp_opcode),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got[127:0]=%h exp[127:0]=%h t=%0t", nm, act[127:0], exp[127:0],
                     $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic logic [DW-1:0] m_result(input logic [2:0] op, input logic [DW-1:0] d,
                                               input logic [SW-1:0] s);
        logic [DW-1:0] r;
        int            sh;
        r  = '0;
        sh = int'(s);
        case (op)
            3'd0: r[0] = ^d;
            3'd1: r = DW'($countones(d));
            3'd2: for (int i = 0; i < int'(DW); i++) r[i] = d[(i + sh) % DW];
            3'd3: for (int i = 0; i < int'(DW); i++) r[(i + sh) % DW] = d[i];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int m_lat(input logic [2:0] op);
        if (op < 3'd2) return NCH + 1;
        if (op < 3'd4) return 2;
        return 1;
    endfunction

    bit            m_busy = 0;
    int            m_wait = 0;
    logic [DW-1:0] m_data = '0;
    logic [2:0]    m_op   = '0;
    logic          m_err  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_wait <= 0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1;
                m_wait <= m_lat(cmd_opcode) - 1;
                m_data <= m_result(cmd_opcode, cmd_data, cmd_shamt);
                m_op   <= cmd_opcode;
                m_err  <= cmd_opcode[2];
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (rsp_ready) begin
            m_busy <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_wait == 0));
            if (m_busy && m_wait == 0) begin
                chkw("rsp_data", rsp_data, m_data);
                chk("rsp_opcode", 64'(rsp_opcode), 64'(m_op));
                chk("rsp_err", 64'(rsp_err), 64'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        int            mode;
        mode = int'($urandom_range(0, 5));
        if (mode == 0) return '0;
        if (mode == 1) return '1;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int hold, output int lat,
                           output logic [DW-1:0] rd, output logic [2:0] rop,
                           output logic rerr);
        int j;
        j = 0;
        while (!cmd_ready && j < 200) begin
            @(posedge clk);
            #1;
            j++;
        end
        if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_data   = d;
        cmd_shamt  = s;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the result must not follow them.
        cmd_valid  = 1'b0;
        cmd_opcode = 3'($urandom);
        cmd_data   = rnd_data();
        cmd_shamt  = SW'($urandom);
        j = 0;
        while (!rsp_valid && j < 200) begin
            @(posedge clk);
            #1;
            j++;
        end
        lat  = j + 1;
        rd   = rsp_data;
        rop  = rsp_opcode;
        rerr = rsp_err;
        for (int k = 0; k < hold; k++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 3'($urandom_range(0, 1));
            cmd_data   = rnd_data();
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chkw("hold_rsp_data", rsp_data, rd);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_ready", 64'(cmd_ready), 64'd1);
        chk("post_hs_valid", 64'(rsp_valid), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int            lat;
        logic [DW-1:0] rd;
        logic [DW-1:0] d;
        logic [2:0]    rop;
        logic          rerr;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_data   = '0;
        cmd_shamt  = '0;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_opcode", 64'(rsp_opcode), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chkw("rst_data", rsp_data, '0);
        rst_n = 1'b1;
        chk("rst_ready", 64'(cmd_ready), 64'd1);

        // Issued right after reset release: accepted on the very next edge.
        d = '0;
        d[0] = 1'b1;
        run_cmd(3'd0, d, '0, 0, lat, rd, rop, rerr);
        chk("par1_lat", 64'(lat), 64'd17);
        chkw("par1_data", rd, DW'(1));
        chk("par1_err", 64'(rerr), 64'd0);
        chk("par1_op", 64'(rop), 64'd0);

        run_cmd(3'd1, '1, '0, 0, lat, rd, rop, rerr);
        chk("pop1_lat", 64'(lat), 64'd17);
        chkw("pop1_data", rd, DW'(1024));
        run_cmd(3'd1, '0, '0, 0, lat, rd, rop, rerr);
        chkw("pop0_data", rd, '0);

        d = '0;
        d[DW-1] = 1'b1;
        d[3:0] = 4'hF;
        run_cmd(3'd3, d, SW'(4), 0, lat, rd, rop, rerr);
        chk("rotl_lat", 64'(lat), 64'd2);
        chkw("rotl_data", rd, DW'(8'hF8));
        chk("rotl_op", 64'(rop), 64'd3);

        d = rnd_data();
        run_cmd(3'd2, d, '0, 0, lat, rd, rop, rerr);
        chkw("rotr0_data", rd, d);
        chk("rotr0_err", 64'(rerr), 64'd0);

        run_cmd(3'd5, d, SW'(7), 0, lat, rd, rop, rerr);
        chk("ill_lat", 64'(lat), 64'd1);
        chkw("ill_data", rd, '0);
        chk("ill_err", 64'(rerr), 64'd1);
        chk("ill_op", 64'(rop), 64'd5);

        d = '0;
        d[70:0] = '1;
        d[900] = 1'b1;
        run_cmd(3'd1, d, '0, 10, lat, rd, rop, rerr);
        chkw("pop_hold_data", rd, DW'(72));

        // Abort a POPCOUNT in its eighth RUN cycle.
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd1;
        cmd_data   = '1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        chkw("mid_rst_data", rsp_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        d = '0;
        d[0] = 1'b1;
        d[500] = 1'b1;
        d[1023] = 1'b1;
        run_cmd(3'd0, d, '0, 0, lat, rd, rop, rerr);
        chk("par_after_rst_lat", 64'(lat), 64'd17);
        chkw("par_after_rst_data", rd, DW'(1));

        // Back-to-back traffic with rsp_ready held, then with random backpressure.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 500; c++) begin
                cmd_valid  = 1'b1;
                cmd_opcode = 3'($urandom_range(0, 7));
                cmd_data   = rnd_data();
                cmd_shamt  = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
                rsp_ready  = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024, operand/result width; power of 2.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 64, bits reduced per cycle; power of 2, divides DATA_WIDTH; NCHUNK = DATA_WIDTH/CHUNK_WIDTH; SW = log2(DATA_WIDTH).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-004 rst_n input 1, asynchronous active-low reset.
REQ-005 cmd_valid input 1, command offered.
REQ-006 cmd_ready output 1, command accepted when cmd_valid && cmd_ready at rising clk.
REQ-007 cmd_opcode input 3, 0=PARITY, 1=POPCOUNT, 2=ROTR, 3=ROTL, 4..7 illegal.
REQ-008 cmd_data input DATA_WIDTH, operand.
REQ-009 cmd_shamt input SW, rotate amount; ignored for opcodes 0/1.
REQ-010 rsp_valid output 1, result available.
REQ-011 rsp_ready input 1, result consumed when rsp_valid && rsp_ready at rising clk.
REQ-012 rsp_opcode output 3, opcode of the command producing rsp_data.
REQ-013 rsp_data output DATA_WIDTH, result.
REQ-014 rsp_err output 1, high with rsp_valid for illegal opcode.
REQ-015 busy output 1, high whenever state != IDLE.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE; one command in flight at a time.
REQ-017 cmd_ready SHALL equal (state == IDLE); no command accepted in RUN or DONE.
REQ-018 On acceptance SHALL latch opcode, data, shamt; later cmd_* changes SHALL not affect the result.
REQ-019 Accept with opcode 0/1: IDLE->RUN, chunk index cleared to 0, accumulator cleared.
REQ-020 PARITY: each RUN cycle XORs the reduction of chunk[index] (LSB chunk first) into accumulator; rsp_data = {zeros, parity bit}.
REQ-021 POPCOUNT: each RUN cycle adds popcount of chunk[index]; accumulator width SW+1; rsp_data = zero-extended count (max DATA_WIDTH, no overflow).
REQ-022 RUN for opcode 0/1 SHALL last exactly NCHUNK cycles, then ->DONE; rsp_valid first high NCHUNK+1 clk edges after acceptance edge.
REQ-023 ROTR/ROTL: one RUN cycle computes rotate by shamt (mod DATA_WIDTH), then ->DONE; rsp_valid high 2 edges after acceptance; shamt 0 returns operand unchanged.
REQ-024 Illegal opcode: IDLE->DONE directly; rsp_data = 0, rsp_err = 1; rsp_valid high 1 edge after acceptance.
REQ-025 rsp_err SHALL be 0 for opcodes 0..3.
REQ-026 In DONE, rsp_valid = 1 and rsp_data/rsp_opcode/rsp_err SHALL hold stable until handshake.
REQ-027 On response handshake SHALL return to IDLE; cmd_ready high the following cycle (no same-cycle accept).
REQ-028 rsp_valid SHALL be 0 in IDLE and RUN; rsp_ready ignored outside DONE.
REQ-029 rsp_ready held high continuously: back-to-back commands SHALL each complete with per-command latency plus 1 IDLE cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, rsp_valid 0, rsp_data 0, rsp_opcode 0, rsp_err 0, busy 0, accumulator/index 0; cmd_ready 1 after deassertion.
REQ-031 Reset in RUN or DONE SHALL abort the command with no response produced.
REQ-032 First command accepted at first rising clk with rst_n high.

Verification
REQ-033 PARITY, data = 1024'h1 -> rsp_valid 17 edges after accept, rsp_data = 1, rsp_err 0, rsp_opcode 0.
REQ-034 POPCOUNT, data = all ones -> rsp_data = 1024 (0x400) after 17 edges; data = 0 -> rsp_data = 0.
REQ-035 ROTL shamt 4, data = 1024'h8000...0F (MSB and low nibble set) -> rsp_data = 1024'hF8 after 2 edges; ROTR shamt 0 -> data unchanged.
REQ-036 Opcode 5 -> rsp_valid after 1 edge, rsp_data 0, rsp_err 1, rsp_opcode 5.
REQ-037 POPCOUNT accepted, rsp_ready held low 10 cycles in DONE -> rsp_* stable, cmd_ready 0, cmd_valid ignored; then handshake -> IDLE.
REQ-038 rst_n pulsed low at RUN cycle 8 of POPCOUNT -> busy 0 immediately, no rsp_valid; next PARITY command completes correctly.
